// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_arbiter_if
//  Brief    : Fetch, load/store and memory-controller buses of cache_arbiter.
//             slave = arbiter side, master = clients/controller side.
//  Revision : 1.0
// ============================================================================
interface cache_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rdy;
    logic [31:0]       i_data;

    logic              d_req;
    logic              d_wr;
    logic [2:0]        d_len;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_rdy;
    logic [31:0]       d_rdata;

    logic              m_req;
    logic              m_wr;
    logic [2:0]        m_len;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_done;
    logic [31:0]       m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_len, d_addr, d_wdata, m_done, m_rdata,
        output i_rdy, i_data, d_rdy, d_rdata, m_req, m_wr, m_len, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_len, d_addr, d_wdata, m_done, m_rdata,
        input  i_rdy, i_data, d_rdy, d_rdata, m_req, m_wr, m_len, m_addr, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_arbiter
//  Brief    : Direct-mapped word icache plus fetch/data arbitration onto a
//             single byte-serial memory-controller port.
//  Revision : 1.0
// ============================================================================
module cache_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int I_INDEX_BITS = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic      clk_in,
    input  wire logic      rst_in,
    input  wire logic      rdy_in,
    input  wire logic      flush,
    cache_arbiter_if.slave bus
);
    localparam int c_ENTRIES = 2 ** I_INDEX_BITS;
    localparam int c_TAG_W   = ADDR_W - 2 - I_INDEX_BITS;
    localparam int c_CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_IFILL = 2'd1;
    localparam logic [1:0] c_DACC  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]              state_q,   state_d;
    logic [c_ENTRIES-1:0]    valid_q,   valid_d;
    logic [c_TAG_W-1:0]      tag_q  [c_ENTRIES];
    logic [c_TAG_W-1:0]      tag_d  [c_ENTRIES];
    logic [31:0]             data_q [c_ENTRIES];
    logic [31:0]             data_d [c_ENTRIES];
    logic [c_CNT_W-1:0]      count_q,   count_d;
    logic                    i_rdy_q,   i_rdy_d;
    logic                    d_rdy_q,   d_rdy_d;
    logic [31:0]             i_data_q,  i_data_d;
    logic [31:0]             d_rdata_q, d_rdata_d;
    logic                    m_req_q,   m_req_d;
    logic                    m_wr_q,    m_wr_d;
    logic [2:0]              m_len_q,   m_len_d;
    logic [ADDR_W-1:0]       m_addr_q,  m_addr_d;
    logic [31:0]             m_wdata_q, m_wdata_d;

    logic [I_INDEX_BITS-1:0] w_i_idx, w_d_idx, w_f_idx;
    logic [c_TAG_W-1:0]      w_i_tag, w_d_tag, w_f_tag;
    logic                    w_i_hit;
    logic                    w_idle_open;
    logic                    w_grant_d, w_grant_hit, w_grant_miss;

    assign w_i_idx = bus.i_addr[I_INDEX_BITS+1:2];
    assign w_i_tag = bus.i_addr[ADDR_W-1:I_INDEX_BITS+2];
    assign w_d_idx = bus.d_addr[I_INDEX_BITS+1:2];
    assign w_d_tag = bus.d_addr[ADDR_W-1:I_INDEX_BITS+2];
    assign w_f_idx = m_addr_q[I_INDEX_BITS+1:2];
    assign w_f_tag = m_addr_q[ADDR_W-1:I_INDEX_BITS+2];

    assign w_i_hit = valid_q[w_i_idx] && (tag_q[w_i_idx] == w_i_tag);

    // While a rdy pulse is on the bus the requester may still be holding the
    // request it answers, so no new grant is issued in that cycle.
    assign w_idle_open  = rdy_in && !flush && (state_q == c_IDLE) && !i_rdy_q && !d_rdy_q;
    assign w_grant_d    = w_idle_open && bus.d_req && ((count_q < c_LIMIT) || !bus.i_req);
    assign w_grant_hit  = w_idle_open && !w_grant_d && bus.i_req && w_i_hit;
    assign w_grant_miss = w_idle_open && !w_grant_d && bus.i_req && !w_i_hit;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (flush) begin
                case (state_q)
                    c_IFILL: state_d = c_IDLE;
                    c_DACC:  state_d = (!m_wr_q || bus.m_done) ? c_IDLE : c_DRAIN;
                    c_DRAIN: state_d = bus.m_done ? c_IDLE : c_DRAIN;
                    default: state_d = state_q;
                endcase
            end else begin
                case (state_q)
                    c_IDLE: begin
                        if (w_grant_d) begin
                            state_d = c_DACC;
                        end else if (w_grant_miss) begin
                            state_d = c_IFILL;
                        end
                    end
                    c_IFILL, c_DACC, c_DRAIN: begin
                        if (bus.m_done) begin
                            state_d = c_IDLE;
                        end
                    end
                    default: state_d = c_IDLE;
                endcase
            end
        end
    end

    // Output and datapath logic
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        count_d   = count_q;
        i_rdy_d   = i_rdy_q;
        d_rdy_d   = d_rdy_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
        m_req_d   = m_req_q;
        m_wr_d    = m_wr_q;
        m_len_d   = m_len_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        if (rdy_in) begin
            i_rdy_d = 1'b0;
            d_rdy_d = 1'b0;
            if (flush) begin
                // A store already on the controller must finish, but silently.
                count_d = '0;
                case (state_q)
                    c_IFILL: m_req_d = 1'b0;
                    c_DACC: begin
                        if (!m_wr_q || bus.m_done) begin
                            m_req_d = 1'b0;
                        end
                    end
                    c_DRAIN: begin
                        if (bus.m_done) begin
                            m_req_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (state_q)
                    c_IDLE: begin
                        if (w_grant_d) begin
                            m_req_d   = 1'b1;
                            m_wr_d    = bus.d_wr;
                            m_len_d   = bus.d_len;
                            m_addr_d  = bus.d_addr;
                            m_wdata_d = bus.d_wdata;
                            if (bus.i_req) begin
                                count_d = count_q + 1'b1;
                            end
                            // Any store touching a cached word kills that line.
                            if (bus.d_wr && (tag_q[w_d_idx] == w_d_tag)) begin
                                valid_d[w_d_idx] = 1'b0;
                            end
                        end else if (w_grant_hit) begin
                            i_rdy_d  = 1'b1;
                            i_data_d = data_q[w_i_idx];
                            count_d  = '0;
                        end else if (w_grant_miss) begin
                            m_req_d  = 1'b1;
                            m_wr_d   = 1'b0;
                            m_len_d  = 3'd3;
                            m_addr_d = bus.i_addr;
                            count_d  = '0;
                        end
                    end
                    c_IFILL: begin
                        if (bus.m_done) begin
                            m_req_d          = 1'b0;
                            valid_d[w_f_idx] = 1'b1;
                            tag_d[w_f_idx]   = w_f_tag;
                            data_d[w_f_idx]  = bus.m_rdata;
                            i_rdy_d          = 1'b1;
                            i_data_d         = bus.m_rdata;
                        end
                    end
                    c_DACC: begin
                        if (bus.m_done) begin
                            m_req_d = 1'b0;
                            d_rdy_d = 1'b1;
                            if (!m_wr_q) begin
                                d_rdata_d = bus.m_rdata;
                            end
                        end
                    end
                    c_DRAIN: begin
                        if (bus.m_done) begin
                            m_req_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q   <= '0;
            count_q   <= '0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_len_q   <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            valid_q   <= valid_d;
            count_q   <= count_d;
            i_rdy_q   <= i_rdy_d;
            d_rdy_q   <= d_rdy_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_len_q   <= m_len_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Tag/data storage is qualified by valid_q and needs no reset.
    always_ff @(posedge clk_in) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // Pulses held across a stall only become visible once rdy_in returns.
    assign bus.i_rdy   = i_rdy_q && rdy_in;
    assign bus.d_rdy   = d_rdy_q && rdy_in;
    assign bus.i_data  = i_data_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.m_req   = m_req_q;
    assign bus.m_wr    = m_wr_q;
    assign bus.m_len   = m_len_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;

endmodule
`default_nettype wire
